// File: rtl/pc_redirect_unit_pkg.sv
// rtl/pc_redirect_unit_pkg.sv - next-PC select encodings, FSM states and helpers for the PC redirect unit
package pc_redirect_unit_pkg;

    typedef enum logic [1:0] {
        PC_NO_BRANCH = 2'b00,
        PC_BRANCH    = 2'b01,
        PC_JALR      = 2'b10,
        PC_RESERVED  = 2'b11
    } pc_sel_e;

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_TRAP = 2'b10
    } pc_state_e;

    localparam logic [31:0] PC_STEP = 32'd4;

    // Only BRANCH and JALR request a redirect; the reserved code is treated as NO_BRANCH.
    function automatic logic is_redirect_sel(input logic [1:0] sel);
        return (sel == PC_BRANCH) || (sel == PC_JALR);
    endfunction

    function automatic logic [31:0] select_target(input logic [1:0]  sel,
                                                  input logic [31:0] br_tgt,
                                                  input logic [31:0] jalr_tgt);
        return (sel == PC_JALR) ? {jalr_tgt[31:1], 1'b0} : br_tgt;
    endfunction

endpackage

// File: rtl/pc_redirect_unit_sat_counter16.sv
// rtl/pc_redirect_unit_sat_counter16.sv - 16-bit up counter that sticks at all-ones
module sat_counter16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    output logic [15:0] count
);

    logic [15:0] count_q;
    logic [15:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 16'h0000;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pc_redirect_unit.sv
// rtl/pc_redirect_unit.sv - fetch PC sequencer with branch/JALR redirect, pipeline flush and misaligned-target trap
module pc_redirect_unit
    import pc_redirect_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  pc_mux_ctrl,
    input  logic        ex_valid,
    input  logic [31:0] br_target,
    input  logic [31:0] jalr_target,
    input  logic        stall,
    input  logic        if_ready,
    input  logic        trap_ack,
    output logic [31:0] pc,
    output logic        if_valid,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic        misalign_exc,
    output logic [15:0] redirect_cnt
);

    pc_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        if_valid_q, if_valid_d;
    logic        misalign_q, misalign_d;

    logic        redirect;
    logic        misaligned;
    logic        cnt_inc;
    logic [31:0] target;

    always_comb begin
        target     = select_target(pc_mux_ctrl, br_target, jalr_target);
        redirect   = (state_q == ST_RUN) && ex_valid && is_redirect_sel(pc_mux_ctrl);
        misaligned = target[1];
        cnt_inc    = redirect && !misaligned;

        state_d    = state_q;
        pc_d       = pc_q;
        misalign_d = misalign_q;

        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                // A redirect wins over stall and over an outstanding fetch.
                if (redirect) begin
                    if (misaligned) begin
                        pc_d       = TRAP_VECTOR;
                        misalign_d = 1'b1;
                        state_d    = ST_TRAP;
                    end else begin
                        pc_d = target;
                    end
                end else if (if_valid_q && if_ready && !stall) begin
                    pc_d = pc_q + PC_STEP;
                end
            end
            ST_TRAP: begin
                if (trap_ack) begin
                    state_d    = ST_RUN;
                    misalign_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase

        if_valid_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_VECTOR;
            if_valid_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_valid_q <= if_valid_d;
            misalign_q <= misalign_d;
        end
    end

    sat_counter16 u_redirect_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (cnt_inc),
        .count (redirect_cnt)
    );

    assign pc           = pc_q;
    assign if_valid     = if_valid_q;
    assign misalign_exc = misalign_q;
    // Flushes are decided in the same cycle the EX stage resolves the redirect.
    assign flush_if_id  = redirect;
    assign flush_id_ex  = redirect;

endmodule
